// File: rtl/mult_arbiter.sv
// Two-requester arbiter in front of one shared shift-add multiplier.
// Latency: the result is valid W rising edges after the accepting edge and is held until taken.
// Backpressure: requests are accepted only in IDLE. A result is held while res_ready is low.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready/a/b (N=0,1)   operand pair handshake per requester
//   res_valid/ready/data/id        product handshake; res_id names the owning requester
//   busy                           high whenever the FSM is not in IDLE
module mult_arbiter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data,
  output logic           res_id,
  output logic           busy
);

  localparam int SW = $clog2(W + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           prio_q,  prio_d;
  logic           owner_q, owner_d;
  logic [W-1:0]   a_sh_q,  a_sh_d;
  logic [2*W-1:0] b_sh_q,  b_sh_d;
  logic [2*W-1:0] acc_q,   acc_d;
  logic [SW-1:0]  step_q,  step_d;

  logic gnt0, gnt1;

  // A lone valid requester wins outright. When both are valid, prio picks the winner.
  // gnt0 and gnt1 are therefore never high together.
  assign gnt0 = req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = req1_valid && (!req0_valid || prio_q);

  // The rst term keeps both readies low while reset is asserted.
  assign req0_ready = !rst && (state_q == IDLE) && gnt0;
  assign req1_ready = !rst && (state_q == IDLE) && gnt1;

  assign res_valid = (state_q == DONE);
  assign res_data  = (state_q == DONE) ? acc_q : '0;
  assign res_id    = owner_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    step_d  = step_q;
    unique case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          owner_d = gnt1;
          // The next tie is given to the requester that just lost.
          prio_d  = !gnt1;
          a_sh_d  = gnt1 ? req1_a : req0_a;
          b_sh_d  = {{W{1'b0}}, (gnt1 ? req1_b : req0_b)};
          acc_d   = '0;
          step_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Always iterate W times, even when a_sh empties early.
        // This keeps the latency independent of the operand values.
        if (a_sh_q[0]) begin
          acc_d = acc_q + b_sh_q;
        end
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q << 1;
        step_d = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter (W=8): directed scenarios plus a random phase.
// Every cycle is checked against a transaction-level reference model.
module tb_mult_arbiter;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req0_valid = 1'b0;
  logic           req0_ready;
  logic [W-1:0]   req0_a = '0;
  logic [W-1:0]   req0_b = '0;
  logic           req1_valid = 1'b0;
  logic           req1_ready;
  logic [W-1:0]   req1_a = '0;
  logic [W-1:0]   req1_b = '0;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [2*W-1:0] res_data;
  logic           res_id;
  logic           busy;

  mult_arbiter #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model state. At the transaction level the unit is either free or owns one
  // operation, which was accepted at cycle m_acc_cyc and whose product is in exp_data.
  bit          m_busy = 1'b0;
  bit          m_prio = 1'b0;
  int          m_acc_cyc = 0;
  logic [31:0] exp_data[$];
  bit          exp_id[$];
  logic [31:0] got_data[$];
  bit          got_id[$];
  int          got_lat[$];
  bit          acc_id[$];
  int          acc_cyc_q[$];

  always @(negedge clk) begin
    bit e0, e1, ev;
    if (rst) begin
      chk("rst_res_valid",  32'(res_valid),  32'd0);
      chk("rst_res_data",   32'(res_data),   32'd0);
      chk("rst_res_id",     32'(res_id),     32'd0);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_req0_ready", 32'(req0_ready), 32'd0);
      chk("rst_req1_ready", 32'(req1_ready), 32'd0);
      m_busy = 1'b0;
      m_prio = 1'b0;
      exp_data.delete();
      exp_id.delete();
    end else begin
      e0 = !m_busy && req0_valid && (!req1_valid || !m_prio);
      e1 = !m_busy && req1_valid && (!req0_valid || m_prio);
      ev = m_busy && ((cyc - m_acc_cyc) >= W);
      chk("busy",       32'(busy),       32'(m_busy));
      chk("req0_ready", 32'(req0_ready), 32'(e0));
      chk("req1_ready", 32'(req1_ready), 32'(e1));
      chk("res_valid",  32'(res_valid),  32'(ev));
      if (res_valid && exp_data.size() > 0) begin
        chk("res_data", 32'(res_data), exp_data[0]);
        chk("res_id",   32'(res_id),   32'(exp_id[0]));
      end
      if (res_valid && res_ready && exp_data.size() > 0) begin
        got_data.push_back(32'(res_data));
        got_id.push_back(res_id);
        got_lat.push_back(cyc - m_acc_cyc);
        void'(exp_data.pop_front());
        void'(exp_id.pop_front());
        m_busy = 1'b0;
      end else if (e0 || e1) begin
        exp_data.push_back(32'(e1 ? req1_a : req0_a) * 32'(e1 ? req1_b : req0_b));
        exp_id.push_back(e1);
        acc_id.push_back(e1);
        acc_cyc_q.push_back(cyc + 1);
        m_busy    = 1'b1;
        m_prio    = !e1;
        m_acc_cyc = cyc + 1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_acc(input int n);
    int k = 0;
    while (acc_id.size() < n && k < 100) begin
      step(1);
      k++;
    end
    chk("wait_accept", 32'(acc_id.size() >= n), 32'd1);
  endtask

  task automatic wait_res(input int n);
    int k = 0;
    while (got_data.size() < n && k < 200) begin
      step(1);
      k++;
    end
    chk("wait_result", 32'(got_data.size() >= n), 32'd1);
  endtask

  task automatic enter_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step(2);
    got_data.delete();
    got_id.delete();
    got_lat.delete();
    acc_id.delete();
    acc_cyc_q.delete();
  endtask

  initial begin
    int k;

    // Basic product from requester 0 after reset.
    step(3);
    req0_a = 8'd13; req0_b = 8'd11; req0_valid = 1'b1; res_ready = 1'b1;
    rst = 1'b0;
    wait_acc(1);
    req0_valid = 1'b0;
    wait_res(1);
    chk("basic_data", got_data[0], 32'd143);
    chk("basic_id",   32'(got_id[0]), 32'd0);
    chk("basic_lat",  32'(got_lat[0]), 32'(W));

    // Both requesters held valid from reset: grants must alternate 0,1,0,1.
    enter_reset();
    req0_a = 8'd255; req0_b = 8'd255; req1_a = 8'd0; req1_b = 8'd200;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    rst = 1'b0;
    wait_res(4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("alt_grant", 32'(acc_id[i]), 32'(i % 2));
      chk("alt_data",  got_data[i], (i % 2 == 0) ? 32'h0000_FE01 : 32'd0);
    end

    // Result held under backpressure; no request is accepted while DONE.
    enter_reset();
    req0_a = 8'd200; req0_b = 8'd3; req0_valid = 1'b1; res_ready = 1'b0;
    rst = 1'b0;
    wait_acc(1);
    req0_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 50) begin
      step(1);
      k++;
    end
    chk("hold_reach_done", 32'(res_valid), 32'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_valid",  32'(res_valid),  32'd1);
      chk("hold_data",   32'(res_data),   32'd600);
      chk("hold_id",     32'(res_id),     32'd0);
      chk("hold_ready0", 32'(req0_ready), 32'd0);
      chk("hold_ready1", 32'(req1_ready), 32'd0);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    step(1);
    chk("take_valid", 32'(res_valid), 32'd0);
    chk("take_busy",  32'(busy),      32'd0);
    chk("take_count", 32'(got_data.size()), 32'd1);

    // Reset in the middle of CALC discards the operation.
    enter_reset();
    req0_a = 8'd255; req0_b = 8'd255; req0_valid = 1'b1; res_ready = 1'b1;
    rst = 1'b0;
    wait_acc(1);
    req0_valid = 1'b0;
    step(3);
    #2;
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("async_res_valid", 32'(res_valid),  32'd0);
    chk("async_busy",      32'(busy),       32'd0);
    chk("async_res_data",  32'(res_data),   32'd0);
    chk("async_ready1",    32'(req1_ready), 32'd0);
    enter_reset();
    req1_a = 8'd2; req1_b = 8'd128; req1_valid = 1'b1;
    rst = 1'b0;
    wait_acc(1);
    req1_valid = 1'b0;
    wait_res(1);
    step(12);
    chk("abort_count", 32'(got_data.size()), 32'd1);
    chk("abort_data",  got_data[0], 32'd256);
    chk("abort_id",    32'(got_id[0]), 32'd1);

    // Back-to-back requests from requester 1 alone.
    enter_reset();
    req1_a = 8'd1; req1_b = 8'd1; req1_valid = 1'b1; res_ready = 1'b1;
    rst = 1'b0;
    wait_acc(1);
    req1_a = 8'd0; req1_b = 8'd0;
    wait_acc(2);
    req1_valid = 1'b0;
    wait_res(2);
    chk("b2b_data0",   got_data[0], 32'd1);
    chk("b2b_data1",   got_data[1], 32'd0);
    chk("b2b_id1",     32'(got_id[1]), 32'd1);
    chk("b2b_spacing", 32'(acc_cyc_q[1] - acc_cyc_q[0]), 32'(W + 2));
    chk("b2b_lat1",    32'(got_lat[1]), 32'(W));

    // Random traffic, including requests withdrawn without a handshake.
    enter_reset();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_a = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      req0_b = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
      req1_a = W'($urandom);
      req1_b = W'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    step(20);
    chk("rand_progress", 32'(got_data.size() >= 10), 32'd1);
    chk("rand_drained",  32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: W, default 8, operand width in bits (2 <= W <= 16).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  W each  requester 0 multiplicand, multiplier.
REQ-007 req1_valid, req1_ready, req1_a, req1_b: same as REQ-004..006, for requester 1.
REQ-008 res_valid  output  1  result available.
REQ-009 res_ready  input  1  consumer takes result.
REQ-010 res_data  output  2W  product.
REQ-011 res_id  output  1  index of the requester that owns res_data.
REQ-012 busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 Block SHALL contain one shared shift-add engine: a_sh (W bits), b_sh (2W bits), acc (2W bits), step counter of ceil(log2(W+1)) bits.
REQ-014 FSM states SHALL be IDLE, CALC and DONE.
REQ-015 IDLE: grant SHALL go to the only valid requester; if both are valid, grant SHALL go to the requester selected by prio.
REQ-016 reqN_ready SHALL be high only in IDLE, only for the granted N, and SHALL be combinational.
REQ-017 Handshake (reqN_valid && reqN_ready) SHALL load a_sh=reqN_a, b_sh=zero-extended reqN_b, acc=0, step=0, owner=N, set prio to 1-N, and move to CALC.
REQ-018 In IDLE with no valid requester, state and prio SHALL be held.
REQ-019 CALC, each cycle: if a_sh[0], then acc <= acc + b_sh; a_sh <= a_sh >> 1; b_sh <= b_sh << 1; step <= step + 1.
REQ-020 CALC SHALL last exactly W cycles regardless of operand values, then move to DONE.
REQ-021 res_valid SHALL be high only in DONE and SHALL first be high on the W-th rising edge after the accepting edge (8 for W=8).
REQ-022 res_data SHALL equal a*b exactly, with no truncation; the maximum value is (2^W-1)^2 (0xFE01 for W=8).
REQ-023 res_id SHALL equal owner; res_data and res_id SHALL hold stable while res_valid && !res_ready.
REQ-024 In DONE with res_ready high, the FSM SHALL go to IDLE on that edge.
REQ-025 No new request SHALL be accepted in CALC or DONE; minimum spacing between accepts is W+2 cycles.
REQ-026 With both requesters continuously valid, grants SHALL strictly alternate, so neither requester starves.
REQ-027 A requester dropping valid without a handshake SHALL have no effect on state.

Reset
REQ-028 rst high SHALL immediately, without waiting for a clock edge, force: state=IDLE, prio=0 (requester 0 favoured), acc=0, a_sh=0, b_sh=0, step=0, owner=0.
REQ-029 During reset, res_valid=0, res_data=0, res_id=0, busy=0, req0_ready=0 and req1_ready=0.
REQ-030 Reset mid-CALC or mid-DONE SHALL discard the in-flight operation; no result for it SHALL ever appear.
REQ-031 The first accept after reset release SHALL occur no earlier than the first rising edge with rst low.

Verification
REQ-032 After reset, req0 a=13 b=11, res_ready=1 -> res_valid 8 edges after accept, res_data=143, res_id=0, busy high throughout.
REQ-033 Both valid from reset: req0 a=255 b=255, req1 a=0 b=200 -> first result 0xFE01 id 0, second result 0 id 1; continuous requests give grants 0,1,0,1.
REQ-034 Hold res_ready=0 for 5 cycles in DONE -> res_valid, res_data and res_id stable, both reqN_ready=0; result taken on the edge where res_ready=1.
REQ-035 Assert rst after step=3 of a CALC -> outputs clear asynchronously with no result emitted; next op req1 a=2 b=128 -> 256, id 1.
REQ-036 Only req1 valid, back-to-back: a=1 b=1 then a=0 b=0 -> results 1 then 0, each after exactly 8 CALC cycles, accepts spaced 10 cycles.
REQ-037 Bench SHALL check every result against the a*b reference and SHALL assert busy == (state != IDLE) on every cycle.
